merget_pulse_counter: RTL and testbench

Clocked pulse-accounting stage placed directly downstream of `mitll_merget`. It samples the merge cell's toggle-encoded `out` stream, where every transition is one SFQ pulse, into a synchronous domain. It counts pulses over fixed windows of `WIN` clock cycles and hands each window total to a consumer over a valid/ready interface with two-entry buffering. With the loss-check option compiled in, it also taps the merge inputs and reports how many pulses the merge swallowed per window.

---
 rtl/merget_pulse_counter.sv | 190 +++++++++++++++++++
 tb/tb_merget_pulse_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/merget_pulse_counter.sv
// Windowed pulse counter for the toggle-encoded output of mitll_merget, with a 2-entry result FIFO.
// Define MERGET_LOSS_CHECK_EN to also tap the merge inputs and report pulses lost per window.
module merget_pulse_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             a_mon,
    input  logic             b_mon,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_ovf,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             drop,
    output logic [CNT_W-1:0] lost_cnt
);
    localparam int unsigned WC_W = $clog2(WIN);

    typedef enum logic {ARM, COUNT} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_arm_cnt;
    logic              r_s1, r_s2, r_s3;
    logic [WC_W-1:0]   r_wc;
    logic [CNT_W-1:0]  r_acc, w_acc_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic [CNT_W-1:0]  r_exp, w_exp_nxt;
    logic [CNT_W-1:0]  w_lost_nxt;
    logic              w_arm, w_counting, w_ed, w_ea, w_eb, w_close, w_pop;
    logic [CNT_W-1:0]  r_q_cnt  [2];
    logic [CNT_W-1:0]  r_q_lost [2];
    logic [1:0]        r_q_ovf;
    logic [1:0]        r_fill;

    assign w_arm      = (r_state == ARM);
    assign w_counting = (r_state == COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARM;
            r_arm_cnt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm ? 1'b1 : r_arm_cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ARM && r_arm_cnt)
            w_state_nxt = COUNT;
    end

    // During ARM the history flop follows the value s2 is about to take, so no edge survives the flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            r_s3 <= w_arm ? r_s1 : r_s2;
        end
    end

    assign w_ed = w_counting & (r_s2 ^ r_s3);

`ifdef MERGET_LOSS_CHECK_EN
    logic r_a1, r_a2, r_a3, r_ea;
    logic r_b1, r_b2, r_b3, r_eb;
    logic [CNT_W:0] w_exp_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_a1, r_a2, r_a3, r_ea} <= '0;
            {r_b1, r_b2, r_b3, r_eb} <= '0;
        end else begin
            r_a1 <= a_mon;
            r_a2 <= r_a1;
            r_a3 <= w_arm ? r_a1 : r_a2;
            r_ea <= w_arm ? 1'b0 : (r_a2 ^ r_a3);
            r_b1 <= b_mon;
            r_b2 <= r_b1;
            r_b3 <= w_arm ? r_b1 : r_b2;
            r_eb <= w_arm ? 1'b0 : (r_b2 ^ r_b3);
        end
    end

    assign w_ea      = w_counting & r_ea;
    assign w_eb      = w_counting & r_eb;
    assign w_exp_sum = {1'b0, r_exp} + (CNT_W+1)'(w_ea) + (CNT_W+1)'(w_eb);
    assign w_exp_nxt = w_exp_sum[CNT_W] ? '1 : w_exp_sum[CNT_W-1:0];
    assign w_lost_nxt = (w_exp_nxt > w_acc_nxt) ? (w_exp_nxt - w_acc_nxt) : '0;
`else
    logic w_unused_mon;
    assign w_unused_mon = a_mon ^ b_mon;
    assign w_ea         = 1'b0;
    assign w_eb         = 1'b0;
    assign w_exp_nxt    = r_exp;
    assign w_lost_nxt   = '0;
`endif

    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (w_ed) begin
            if (r_acc == '1)
                w_ovf_nxt = 1'b1;
            else
                w_acc_nxt = r_acc + CNT_W'(1);
        end
    end

    assign w_close = w_counting && (r_wc == WC_W'(WIN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wc  <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_exp <= '0;
        end else if (w_counting) begin
            if (w_close) begin
                r_wc  <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_exp <= '0;
            end else begin
                r_wc  <= r_wc + WC_W'(1);
                r_acc <= w_acc_nxt;
                r_ovf <= w_ovf_nxt;
                r_exp <= w_exp_nxt;
            end
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down and a concurrent push refills behind it
    assign w_pop = (r_fill != 2'd0) && cnt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_cnt[0]  <= '0;
            r_q_cnt[1]  <= '0;
            r_q_lost[0] <= '0;
            r_q_lost[1] <= '0;
            r_q_ovf     <= '0;
            r_fill      <= 2'd0;
            drop        <= 1'b0;
        end else if (w_pop) begin
            r_q_cnt[0]  <= r_q_cnt[1];
            r_q_lost[0] <= r_q_lost[1];
            r_q_ovf[0]  <= r_q_ovf[1];
            if (w_close) begin
                if (r_fill == 2'd1) begin
                    r_q_cnt[0]  <= w_acc_nxt;
                    r_q_lost[0] <= w_lost_nxt;
                    r_q_ovf[0]  <= w_ovf_nxt;
                end else begin
                    r_q_cnt[1]  <= w_acc_nxt;
                    r_q_lost[1] <= w_lost_nxt;
                    r_q_ovf[1]  <= w_ovf_nxt;
                end
            end else begin
                r_fill <= r_fill - 2'd1;
            end
        end else if (w_close) begin
            if (r_fill == 2'd0) begin
                r_q_cnt[0]  <= w_acc_nxt;
                r_q_lost[0] <= w_lost_nxt;
                r_q_ovf[0]  <= w_ovf_nxt;
                r_fill      <= 2'd1;
            end else if (r_fill == 2'd1) begin
                r_q_cnt[1]  <= w_acc_nxt;
                r_q_lost[1] <= w_lost_nxt;
                r_q_ovf[1]  <= w_ovf_nxt;
                r_fill      <= 2'd2;
            end else begin
                drop <= 1'b1;
            end
        end
    end

    assign cnt_out   = r_q_cnt[0];
    assign cnt_ovf   = r_q_ovf[0];
    assign lost_cnt  = r_q_lost[0];
    assign cnt_valid = (r_fill != 2'd0);
endmodule

// File: tb/tb_merget_pulse_counter.sv
// Directed bench for merget_pulse_counter: a CNT_W=8 instance plus a CNT_W=3 instance for saturation.
// Edge numbers below count rising edges after rst_n release; inputs change and outputs are sampled 1 ns after an edge.
module tb_merget_pulse_counter;
    logic       clk = 1'b0;
    logic       rst_n, din, a_mon, b_mon, cnt_ready;
    logic [7:0] cnt_out, lost_cnt;
    logic       cnt_ovf, cnt_valid, drop;
    logic [2:0] s_cnt_out, s_lost_cnt;
    logic       s_cnt_ovf, s_cnt_valid, s_drop;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         exp_lost;

    always #5 clk = ~clk;

    merget_pulse_counter #(.CNT_W(8), .WIN(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .a_mon(a_mon), .b_mon(b_mon),
        .cnt_out(cnt_out), .cnt_ovf(cnt_ovf), .cnt_valid(cnt_valid),
        .cnt_ready(cnt_ready), .drop(drop), .lost_cnt(lost_cnt)
    );

    merget_pulse_counter #(.CNT_W(3), .WIN(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .din(din), .a_mon(a_mon), .b_mon(b_mon),
        .cnt_out(s_cnt_out), .cnt_ovf(s_cnt_ovf), .cnt_valid(s_cnt_valid),
        .cnt_ready(cnt_ready), .drop(s_drop), .lost_cnt(s_lost_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    initial begin
`ifdef MERGET_LOSS_CHECK_EN
        exp_lost = 3;
`else
        exp_lost = 0;
`endif
        rst_n = 1'b0; din = 1'b1; a_mon = 1'b0; b_mon = 1'b0; cnt_ready = 1'b0;
        repeat (3) tick();
        check("rst_cnt_out",   int'(cnt_out),   0);
        check("rst_cnt_ovf",   int'(cnt_ovf),   0);
        check("rst_cnt_valid", int'(cnt_valid), 0);
        check("rst_drop",      int'(drop),      0);
        check("rst_lost_cnt",  int'(lost_cnt),  0);

        // din held high through reset must not produce an event
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 17) tick();
        check("arm_valid_early", int'(cnt_valid), 0);
        tick();
        check("arm_valid_w1", int'(cnt_valid), 1);
        check("arm_cnt_w1",   int'(cnt_out),   0);

        // steady stream: toggle every 4 edges, counted 3 edges later -> 4 per window
        cnt_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            din = ~din;
            for (int j = 0; j < 4; j++) begin
                tick();
                if (cyc == 34 || cyc == 50 || cyc == 66) begin
                    check("steady_cnt",   int'(cnt_out),   4);
                    check("steady_ovf",   int'(cnt_ovf),   0);
                    check("steady_valid", int'(cnt_valid), 1);
                end
                if (cyc == 34) check("steady_small_cnt", int'(s_cnt_out), 4);
                if (cyc == 35) check("steady_popped", int'(cnt_valid), 0);
            end
        end

        // saturation: 8 toggles land in window 6 (edges 83..98)
        while (cyc < 80) tick();
        for (int k = 0; k < 8; k++) begin
            din = ~din;
            tick();
            tick();
            if (cyc == 82) check("quiet_w5_cnt", int'(cnt_out), 0);
        end
        while (cyc < 98) tick();
        check("sat_wide_cnt",  int'(cnt_out),   8);
        check("sat_wide_ovf",  int'(cnt_ovf),   0);
        check("sat_small_cnt", int'(s_cnt_out), 7);
        check("sat_small_ovf", int'(s_cnt_ovf), 1);

        // backpressure: windows 7/8/9 carry 1/2/3 pulses
        tick();
        cnt_ready = 1'b0;
        while (cyc < 102) tick();
        din = ~din;
        while (cyc < 114) tick();
        check("bp_w7_valid", int'(cnt_valid), 1);
        check("bp_w7_cnt",   int'(cnt_out),   1);
        while (cyc < 118) tick();
        din = ~din;
        while (cyc < 122) tick();
        din = ~din;
        while (cyc < 130) tick();
        check("bp_w8_held",  int'(cnt_out),   1);
        check("bp_w8_valid", int'(cnt_valid), 1);
        check("bp_w8_drop",  int'(drop),      0);
        while (cyc < 134) tick();
        din = ~din;
        while (cyc < 138) tick();
        din = ~din;
        while (cyc < 142) tick();
        din = ~din;
        while (cyc < 146) tick();
        check("bp_w9_drop", int'(drop),    1);
        check("bp_w9_head", int'(cnt_out), 1);
        cnt_ready = 1'b1;
        tick();
        check("bp_pop1_cnt",   int'(cnt_out),   2);
        check("bp_pop1_valid", int'(cnt_valid), 1);
        tick();
        check("bp_pop2_valid", int'(cnt_valid), 0);

        // reset mid-window: 5 toggles in window 10, reset asserted while wc = 9
        for (int k = 0; k < 5; k++) begin
            din = ~din;
            tick();
        end
        while (cyc < 155) tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("mid_rst_valid", int'(cnt_valid), 0);
        check("mid_rst_drop",  int'(drop),      0);
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 5) tick();
        din = ~din;
        while (cyc < 9) tick();
        din = ~din;
        while (cyc < 17) tick();
        check("post_rst_valid_early", int'(cnt_valid), 0);
        tick();
        check("post_rst_valid", int'(cnt_valid), 1);
        check("post_rst_cnt",   int'(cnt_out),   2);

        // loss check: a and b toggle together 3 times, din only 3 times, all inside window 2
        while (cyc < 20) tick();
        for (int k = 0; k < 3; k++) begin
            a_mon = ~a_mon;
            b_mon = ~b_mon;
            tick();
            din = ~din;
            repeat (3) tick();
        end
        while (cyc < 34) tick();
        check("loss_cnt",   int'(cnt_out),  3);
        check("loss_lost",  int'(lost_cnt), exp_lost);
        check("loss_ovf",   int'(cnt_ovf),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
